// File: rtl/stream_matrix_pkg.sv
// Shared types and helpers for the stream-to-matrix writer.
package stream_matrix_pkg;

    // Writer sequencing: gather a row, write it, and after the last row pulse done.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } writer_state_t;

    // Index width for a counter over n values. Never returns less than one bit,
    // so that single-row or single-column matrices still get a legal vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_matrix_writer_counter_mod.sv
// Modulo-MOD up counter with a synchronous clear. The reset is asynchronous and
// active-low, matching the writer that instantiates it.
module counter_mod #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reset_count,
    input  logic         up,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear has priority over counting; the count wraps from MOD-1 back to 0.
    always_comb begin
        count_d = count_q;
        if (reset_count) begin
            count_d = '0;
        end else if (up) begin
            if (count_q == W'(MOD - 1)) begin
                count_d = '0;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stream_matrix_writer.sv
// Stream-to-matrix sink: packs NUM_COLS stream elements into a row buffer and
// writes each completed row through a row-wide write port. A sticky flag reports
// when the producer's ds_last marker disagrees with the fixed matrix size.
module stream_matrix_writer
    import stream_matrix_pkg::*;
#(
    parameter int  WIDTH          = 32,
    parameter int  NUM_ROWS       = 11,
    parameter int  NUM_COLS       = 3,
    localparam int ROW_ADDR_WIDTH = clog2_min1(NUM_ROWS),
    localparam int COL_ADDR_WIDTH = clog2_min1(NUM_COLS),
    localparam int ROW_SIZE       = NUM_COLS * WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          ds_in,
    input  logic                      ds_valid,
    input  logic                      ds_last,
    output logic                      ds_next_data,
    output logic [ROW_ADDR_WIDTH-1:0] row_addr,
    output logic [ROW_SIZE-1:0]       row_in,
    output logic                      row_write_en,
    output logic                      done,
    output logic                      length_error
);

    writer_state_t             state_q;
    writer_state_t             state_d;
    logic [ROW_SIZE-1:0]       buf_q;
    logic                      length_error_q;

    logic [COL_ADDR_WIDTH-1:0] col;
    logic [ROW_ADDR_WIDTH-1:0] row;
    logic                      transfer;
    logic                      accept;
    logic                      col_last;
    logic                      row_last;
    logic                      last_expected;

    // ds_next_data depends only on state, so the handshake is decoded straight
    // from the state register to keep the counter enable free of comb loops.
    assign transfer      = (state_q == FILL) && ds_valid;
    // A start in the same cycle wins: the element is dropped.
    assign accept        = transfer && !start;
    assign col_last      = (col == COL_ADDR_WIDTH'(NUM_COLS - 1));
    assign row_last      = (row == ROW_ADDR_WIDTH'(NUM_ROWS - 1));
    assign last_expected = col_last && row_last;

    counter_mod #(
        .MOD (NUM_COLS),
        .W   (COL_ADDR_WIDTH)
    ) u_col_counter (
        .clk         (clk),
        .rst_n       (rst),
        .reset_count (start),
        .up          (transfer),
        .count       (col)
    );

    counter_mod #(
        .MOD (NUM_ROWS),
        .W   (ROW_ADDR_WIDTH)
    ) u_row_counter (
        .clk         (clk),
        .rst_n       (rst),
        .reset_count (start),
        .up          (state_q == WRITE),
        .count       (row)
    );

    // Next-state and strobes; start from any state restarts the matrix in FILL.
    always_comb begin
        state_d      = state_q;
        ds_next_data = 1'b0;
        row_write_en = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                ds_next_data = 1'b1;
                if (start) begin
                    state_d = FILL;
                end else if (transfer && col_last) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // An abort landing on the write cycle cancels that write.
                row_write_en = !start;
                if (start) begin
                    state_d = FILL;
                end else if (row_last) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? FILL : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, row buffer and sticky length-error flag. The buffer is not cleared
    // on start; stale columns are always overwritten before the next write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            buf_q          <= '0;
            length_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                length_error_q <= 1'b0;
            end else if (accept) begin
                buf_q[int'(col) * WIDTH +: WIDTH] <= ds_in;
                if (ds_last != last_expected) begin
                    length_error_q <= 1'b1;
                end
            end
        end
    end

    assign row_addr     = row;
    assign row_in       = buf_q;
    assign length_error = length_error_q;

endmodule
